// File: rtl/prefix3_seq_adder.sv
// Sequential radix-3 Kogge-Stone adder: one prefix level per clock.
// Optional PREFIX3_OVF_EN adds a registered signed-overflow output.
module prefix3_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PREFIX3_OVF_EN
  ,
  output logic             ovf
`endif
);

  function automatic int calcLevels(input int w);
    int l;
    int p;
    l = 1;
    p = 3;
    for (int j = 0; j < 6; j++) begin
      if (p < w + 1) begin
        p = p * 3;
        l = l + 1;
      end
    end
    return l;
  endfunction

  function automatic int pow3(input logic [2:0] n);
    int r;
    r = 1;
    for (int j = 0; j < 7; j++) begin
      if (3'(j) < n) r = r * 3;
    end
    return r;
  endfunction

  localparam int LEVELS = calcLevels(WIDTH);
  localparam logic [2:0] LAST = 3'(LEVELS - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMB,
    DONE
  } stateT;

  stateT state;
  stateT stateNext;

  // Bit k holds prefix position k-1, so bit 0 is the carry-in slot.
  logic [WIDTH:0]   g;
  logic [WIDTH:0]   p;
  logic [WIDTH:0]   gNext;
  logic [WIDTH:0]   pNext;
  logic [WIDTH:0]   gs1;
  logic [WIDTH:0]   gs2;
  logic [WIDTH:0]   ps1;
  logic [WIDTH:0]   ps2;
  logic [WIDTH-1:0] x;
  logic [2:0]       lvl;
  int               d;

  // Shift-in fills supply the identity (G=0, P=1) below position -1.
  always_comb begin
    d     = pow3(lvl);
    gs1   = g << d;
    gs2   = g << (2 * d);
    ps1   = ~((~p) << d);
    ps2   = ~((~p) << (2 * d));
    gNext = g | (p & (gs1 | (ps1 & gs2)));
    pNext = p & ps1 & ps2;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) stateNext = COMB;
      end
      COMB: begin
        if (lvl == LAST) stateNext = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      g    <= '0;
      p    <= '0;
      x    <= '0;
      lvl  <= '0;
      sum  <= '0;
      cout <= 1'b0;
`ifdef PREFIX3_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      g   <= {a & b, cin};
      p   <= {a | b, 1'b0};
      x   <= a ^ b;
      lvl <= '0;
    end else if (state == COMB) begin
      g   <= gNext;
      p   <= pNext;
      lvl <= lvl + 3'd1;
      if (lvl == LAST) begin
        sum  <= x ^ gNext[WIDTH-1:0];
        cout <= gNext[WIDTH];
`ifdef PREFIX3_OVF_EN
        ovf  <= gNext[WIDTH] ^ gNext[WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_prefix3_seq_adder.sv
// Bench for prefix3_seq_adder: arithmetic reference model plus
// directed literal vectors, backpressure, reset abort and streaming.
module tb_prefix3_seq_adder;

  localparam int W   = 16;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
`ifdef PREFIX3_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  prefix3_seq_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout)
`ifdef PREFIX3_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: transaction-level, result known at accept.
  int           mState = 0;
  int           mCnt = 0;
  logic         mValid = 1'b0;
  logic [W-1:0] mSum = '0;
  logic [W-1:0] pSum = '0;
  logic         mCout = 1'b0;
  logic         pCout = 1'b0;
  logic         mOvf = 1'b0;
  logic         pOvf = 1'b0;
  int           cyc = 0;
  int           accCount = 0;
  bit           accNow = 1'b0;
  bit           bbMode = 1'b0;
  int           dutLast = -1;

  always @(posedge clk) begin
    cyc++;
    accNow = 1'b0;
    if (bbMode && !reset && in_valid && in_ready) begin
      if (dutLast >= 0) chk("issue_interval", cyc - dutLast, LAT + 2);
      dutLast = cyc;
    end
    if (reset) begin
      mState = 0;
      mValid = 1'b0;
    end else begin
      case (mState)
        0: if (in_valid) begin
          {pCout, pSum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
          pOvf = (a[W-1] == b[W-1]) && (pSum[W-1] != a[W-1]);
          mCnt = LAT;
          mState = 1;
          accNow = 1'b1;
          accCount++;
        end
        1: begin
          mCnt--;
          if (mCnt == 0) begin
            mState = 2;
            mValid = 1'b1;
            mSum = pSum;
            mCout = pCout;
            mOvf = pOvf;
          end
        end
        default: if (out_ready) begin
          mState = 0;
          mValid = 1'b0;
        end
      endcase
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("in_ready", in_ready, 32'(mState == 0));
      chk("out_valid", out_valid, 32'(mValid));
      if (mValid) begin
        chk("sum", sum, mSum);
        chk("cout", cout, mCout);
`ifdef PREFIX3_OVF_EN
        chk("ovf", ovf, mOvf);
`endif
      end
    end
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc);
    a = ta;
    b = tb;
    cin = tc;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitValid(output int n);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1) break;
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int n;
  int target;

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
`ifdef PREFIX3_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;

    issue(16'hFFFF, 16'h0001, 1'b0);
    waitValid(n);
    chk("wrap_latency", n, LAT + 1);
    chk("wrap_sum", sum, 16'h0000);
    chk("wrap_cout", cout, 1);
    release_op();

    issue(16'h1234, 16'h4321, 1'b1);
    waitValid(n);
    chk("cin_sum", sum, 16'h5556);
    chk("cin_cout", cout, 0);
`ifdef PREFIX3_OVF_EN
    chk("cin_ovf", ovf, 0);
`endif
    release_op();

    issue(16'hFFFF, 16'hFFFF, 1'b1);
    waitValid(n);
    chk("ones_sum", sum, 16'hFFFF);
    chk("ones_cout", cout, 1);
    release_op();

    out_ready = 1'b0;
    issue(16'h00FF, 16'h0F0F, 1'b0);
    waitValid(n);
    chk("bp_latency", n, LAT + 1);
    for (int i = 0; i < 5; i++) begin
      a = 16'h0001;
      b = 16'h0001;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", sum, 16'h100E);
      chk("bp_cout", cout, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_ready_after", in_ready, 1);
    chk("bp_valid_after", out_valid, 0);

    issue(16'hAAAA, 16'h5555, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
`ifdef PREFIX3_OVF_EN
    chk("abort_ovf", ovf, 0);
`endif
    issue(16'h0003, 16'h0004, 1'b0);
    waitValid(n);
    chk("post_abort_sum", sum, 16'h0007);
    release_op();

    issue(16'h7FFF, 16'h0001, 1'b0);
    waitValid(n);
    chk("sov1_sum", sum, 16'h8000);
    chk("sov1_cout", cout, 0);
`ifdef PREFIX3_OVF_EN
    chk("sov1_ovf", ovf, 1);
`endif
    release_op();

    issue(16'h8000, 16'h8000, 1'b0);
    waitValid(n);
    chk("sov2_sum", sum, 16'h0000);
    chk("sov2_cout", cout, 1);
`ifdef PREFIX3_OVF_EN
    chk("sov2_ovf", ovf, 1);
`endif
    release_op();

    bbMode = 1'b1;
    dutLast = -1;
    out_ready = 1'b1;
    target = accCount + 100;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    in_valid = 1'b1;
    for (int k = 0; k < 1500 && accCount < target; k++) begin
      @(posedge clk);
      #1;
      if (accNow) begin
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    if (accCount < target) chk("bb_timeout", accCount, target);
    repeat (10) @(posedge clk);
    bbMode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
